// File: rtl/freq_inversion.sv
// freq_inversion: applies MP3 frequency inversion (negate odd time slots of odd subbands)
// and reorders one granule from subband-major input to time-slot-major output through a
// ping-pong pair of granule banks.
module freq_inversion #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NSB    = 32,
    parameter int unsigned NTS    = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_freqinv_data,
    input  logic              in_freqinv_valid,
    output logic              in_freqinv_ready,
    output logic [DATA_W-1:0] out_freqinv_data,
    output logic [4:0]        out_freqinv_sb,
    output logic [4:0]        out_freqinv_ts,
    output logic              out_freqinv_last,
    output logic              out_freqinv_valid,
    input  logic              out_freqinv_ready
);

    localparam int unsigned Depth = NSB * NTS;
    localparam int unsigned AW    = $clog2(Depth);
    localparam logic [4:0]  SbMax = 5'(NSB - 1);
    localparam logic [4:0]  TsMax = 5'(NTS - 1);
    localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

    bank_st_e          bank_st_q [2];
    bank_st_e          bank_st_d [2];
    logic [DATA_W-1:0] mem_q [2][Depth];

    logic              wr_bank_q, rd_bank_q;
    logic              fetch_bank_q, fetch_act_q;
    logic              ready_en_q;
    logic [4:0]        sb_w_q, ts_w_q, sb_r_q, ts_r_q;

    logic [DATA_W-1:0] out_data_q;
    logic [4:0]        out_sb_q, out_ts_q;
    logic              out_last_q, out_valid_q;

    logic              in_hs, wr_last, out_hs, last_hs;
    logic              load_ok, fetch, fetch_last, sel_bank, select;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [DATA_W-1:0] neg_data, wr_data;

    assign in_hs      = in_freqinv_valid && in_freqinv_ready;
    assign wr_last    = in_hs && (sb_w_q == SbMax) && (ts_w_q == TsMax);
    assign out_hs     = out_valid_q && out_freqinv_ready;
    assign last_hs    = out_hs && out_last_q;

    // The output register can take a new beat when empty or being accepted this cycle.
    assign load_ok    = !out_valid_q || out_freqinv_ready;
    assign fetch      = fetch_act_q && load_ok;
    assign fetch_last = fetch && (sb_r_q == SbMax) && (ts_r_q == TsMax);

    // While the fetcher is reading its final beat it may already claim the other bank, so
    // consecutive granules leave the output port without a bubble.
    assign sel_bank   = fetch_act_q ? ~fetch_bank_q : fetch_bank_q;
    assign select     = (!fetch_act_q || fetch_last) && (bank_st_q[sel_bank] == StFull);

    assign wr_addr    = AW'(sb_w_q) * AW'(NTS) + AW'(ts_w_q);
    assign rd_addr    = AW'(sb_r_q) * AW'(NTS) + AW'(ts_r_q);

    // Saturating negation: only the most negative value needs clamping.
    assign neg_data   = (in_freqinv_data == MinVal) ? MaxVal : -in_freqinv_data;
    assign wr_data    = (sb_w_q[0] && ts_w_q[0]) ? neg_data : in_freqinv_data;

    // Bank state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_st_q[0] <= StEmpty;
            bank_st_q[1] <= StEmpty;
        end else begin
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
        end
    end

    // Bank next-state: fill, complete, claim by the reader, release on the last handshake.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_d[b] = bank_st_q[b];
            unique case (bank_st_q[b])
                StEmpty:    if (in_hs && wr_bank_q == 1'(b)) bank_st_d[b] = StFilling;
                StFilling:  if (wr_last && wr_bank_q == 1'(b)) bank_st_d[b] = StFull;
                StFull:     if (select && sel_bank == 1'(b)) bank_st_d[b] = StDraining;
                StDraining: if (last_hs && rd_bank_q == 1'(b)) bank_st_d[b] = StEmpty;
                default:    bank_st_d[b] = StEmpty;
            endcase
        end
    end

    // Input ready: the write bank can still take samples (held low until the first edge).
    always_comb begin
        in_freqinv_ready = ready_en_q && ((bank_st_q[wr_bank_q] == StEmpty) ||
                                          (bank_st_q[wr_bank_q] == StFilling));
    end

    // Write/read counters and bank pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q   <= 1'b0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            fetch_bank_q <= 1'b0;
            fetch_act_q  <= 1'b0;
            sb_w_q       <= '0;
            ts_w_q       <= '0;
            sb_r_q       <= '0;
            ts_r_q       <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (in_hs) begin
                if (ts_w_q == TsMax) begin
                    ts_w_q <= '0;
                    sb_w_q <= (sb_w_q == SbMax) ? '0 : sb_w_q + 5'd1;
                end else begin
                    ts_w_q <= ts_w_q + 5'd1;
                end
            end
            if (wr_last) wr_bank_q <= ~wr_bank_q;
            if (last_hs) rd_bank_q <= ~rd_bank_q;
            if (fetch) begin
                if (sb_r_q == SbMax) begin
                    sb_r_q <= '0;
                    ts_r_q <= (ts_r_q == TsMax) ? '0 : ts_r_q + 5'd1;
                end else begin
                    sb_r_q <= sb_r_q + 5'd1;
                end
            end
            if (fetch_last) begin
                fetch_bank_q <= ~fetch_bank_q;
                fetch_act_q  <= select;
            end else if (select) begin
                fetch_act_q  <= 1'b1;
            end
        end
    end

    // Sample storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (in_hs) mem_q[wr_bank_q][wr_addr] <= wr_data;
    end

    // Output register: loads a prefetched beat when empty or accepted, otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sb_q    <= '0;
            out_ts_q    <= '0;
            out_last_q  <= 1'b0;
        end else if (fetch) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[fetch_bank_q][rd_addr];
            out_sb_q    <= sb_r_q;
            out_ts_q    <= ts_r_q;
            out_last_q  <= (sb_r_q == SbMax) && (ts_r_q == TsMax);
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_freqinv_data  = out_data_q;
    assign out_freqinv_sb    = out_sb_q;
    assign out_freqinv_ts    = out_ts_q;
    assign out_freqinv_last  = out_last_q;
    assign out_freqinv_valid = out_valid_q;

endmodule

// File: tb/tb_freq_inversion.sv
// Directed bench for freq_inversion: ordering, inversion, saturation, backpressure,
// ping-pong streaming, both-banks-full stall and asynchronous reset mid-operation.
module tb_freq_inversion;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [4:0]  out_sb;
    logic [4:0]  out_ts;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    freq_inversion #(
        .DATA_W(32),
        .NSB   (32),
        .NTS   (18)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_freqinv_data  (in_data),
        .in_freqinv_valid (in_valid),
        .in_freqinv_ready (in_ready),
        .out_freqinv_data (out_data),
        .out_freqinv_sb   (out_sb),
        .out_freqinv_ts   (out_ts),
        .out_freqinv_last (out_last),
        .out_freqinv_valid(out_valid),
        .out_freqinv_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] src[$];
    int          src_idx;
    logic [42:0] exp_q[$];            // {last, ts, sb, data}
    logic [31:0] gran_buf[576];
    int          gran_pos;
    logic [31:0] obs_log[576];
    int          in_tick[2048];
    int          out_tick[2048];
    int          in_cnt, out_cnt, cyc;
    int          first_valid_tick, last_in_tick, hold_cnt;
    int          rdy_mode;            // 0 low, 1 high, 2 random
    logic        hold_pend, saw_last, obs_in_ready;
    logic [42:0] hold_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sat_neg(input logic [31:0] x);
        if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
        return -x;
    endfunction

    // Golden model: collect one granule in arrival order, emit expected time-slot-major beats.
    task automatic model_push(input logic [31:0] x);
        logic [31:0] v;
        gran_buf[gran_pos] = x;
        gran_pos++;
        if (gran_pos == 576) begin
            for (int ts = 0; ts < 18; ts++) begin
                for (int sb = 0; sb < 32; sb++) begin
                    v = gran_buf[sb * 18 + ts];
                    if ((sb % 2 == 1) && (ts % 2 == 1)) v = sat_neg(v);
                    exp_q.push_back({(ts == 17 && sb == 31), 5'(ts), 5'(sb), v});
                end
            end
            gran_pos = 0;
        end
    endtask

    task automatic new_test();
        in_cnt = 0;
        out_cnt = 0;
        first_valid_tick = -1;
        hold_cnt = 0;
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later, handshake at next rise.
    task automatic tick();
        logic [42:0] beat;
        @(negedge clk);
        if (src_idx < src.size()) begin
            in_valid = 1'b1;
            in_data  = src[src_idx];
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        cyc++;
        beat = {out_last, out_ts, out_sb, out_data};
        if (hold_pend) check("hold_stable", {out_valid, beat}, {1'b1, hold_val});
        hold_pend = out_valid && !out_ready;
        hold_val  = beat;
        if (hold_pend) hold_cnt++;
        if (out_valid && first_valid_tick < 0) first_valid_tick = cyc;
        if (in_valid && in_ready) begin
            model_push(in_data);
            if (in_cnt < 2048) in_tick[in_cnt] = cyc;
            in_cnt++;
            src_idx++;
            last_in_tick = cyc;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", out_valid, 1'b0);
            end else begin
                check("beat", beat, exp_q.pop_front());
            end
            obs_log[out_cnt % 576] = out_data;
            if (out_cnt < 2048) out_tick[out_cnt] = cyc;
            out_cnt++;
            if (out_last) saw_last = 1'b1;
        end
        obs_in_ready = in_ready;
    endtask

    task automatic run_src(input int budget);
        int n;
        n = 0;
        while (src_idx < src.size() && n < budget) begin tick(); n++; end
        check("src_all_sent", src_idx, src.size());
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin tick(); n++; end
        check("all_beats_out", exp_q.size(), 0);
    endtask

    task automatic run_until_in(input int target, input int budget);
        int n;
        n = 0;
        while (in_cnt < target && n < budget) begin tick(); n++; end
        check("in_count_reached", in_cnt, target);
    endtask

    task automatic run_until_out(input int target, input int budget);
        int n;
        n = 0;
        while (out_cnt < target && n < budget) begin tick(); n++; end
        check("out_count_reached", out_cnt, target);
    endtask

    task automatic run_until_last(input int budget);
        int n;
        n = 0;
        saw_last = 1'b0;
        while (!saw_last && n < budget) begin tick(); n++; end
        check("last_seen", saw_last, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"},  out_data,  32'h0);
        check({tag, "_out_sb"},    out_sb,    5'd0);
        check({tag, "_out_ts"},    out_ts,    5'd0);
        check({tag, "_out_last"},  out_last,  1'b0);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        src_idx = 0;
        gran_pos = 0;
        cyc = 0;
        rdy_mode = 1;
        hold_pend = 1'b0;
        saw_last = 1'b0;
        new_test();

        // Reset values, then ready rises on the first edge after release
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        #1 reset = 1'b1;
        #1 check("ready_before_first_edge", in_ready, 1'b0);
        tick();
        check("ready_after_first_edge", obs_in_ready, 1'b1);

        // Single granule: x[i] = i+1
        new_test();
        for (int i = 0; i < 576; i++) src.push_back(32'(i + 1));
        run_src(700);
        run_drain(700);
        check("g1_latency", first_valid_tick - last_in_tick, 3);
        check("g1_beat1",   obs_log[1],   32'd19);
        check("g1_beat32",  obs_log[32],  32'd2);
        check("g1_beat33",  obs_log[33],  32'hFFFF_FFEC);
        check("g1_beat575", obs_log[575], 32'hFFFF_FDC0);
        check("g1_beats",   out_cnt, 576);

        // Saturation at (sb=1,ts=1) and pass-through at (sb=0,ts=0)
        new_test();
        for (int i = 0; i < 576; i++) begin
            src.push_back((i == 0 || i == 19) ? 32'h8000_0000 : 32'(i + 1));
        end
        run_src(700);
        run_drain(700);
        check("sat_beat0",  obs_log[0],  32'h8000_0000);
        check("sat_beat33", obs_log[33], 32'h7FFF_FFFF);

        // Random backpressure over one granule
        new_test();
        rdy_mode = 2;
        for (int i = 0; i < 576; i++) src.push_back(32'(i * 7) - 32'd1000);
        run_src(700);
        run_drain(3000);
        check("bp_exercised", hold_cnt != 0, 1'b1);
        check("bp_beats", out_cnt, 576);

        // Three back-to-back granules, ready always high
        new_test();
        rdy_mode = 1;
        for (int i = 0; i < 1728; i++) begin
            src.push_back((i % 3 == 0) ? -32'(i) : 32'h1000_0000 + 32'(i * 5));
        end
        run_src(2000);
        run_drain(700);
        check("pp_in_contig_g12",  in_tick[1151] - in_tick[0], 1151);
        check("pp_out_contig_g12", out_tick[1151] - out_tick[0], 1151);
        check("pp_in_contig_g3",   in_tick[1727] - in_tick[1152], 575);
        check("pp_out_contig_g3",  out_tick[1727] - out_tick[1152], 575);
        check("pp_first_latency",  out_tick[0] - in_tick[575], 3);
        check("pp_beats", out_cnt, 1728);

        // Both banks full: stall input until the first granule's last handshake
        new_test();
        rdy_mode = 0;
        for (int i = 0; i < 1152; i++) src.push_back(32'h0BAD_0000 ^ 32'(i * 11));
        run_src(1300);
        tick();
        check("full_ready_low", obs_in_ready, 1'b0);
        repeat (4) tick();
        check("full_ready_still_low", obs_in_ready, 1'b0);
        check("full_out_valid_held", out_valid, 1'b1);
        rdy_mode = 1;
        run_until_last(700);
        check("full_ready_at_last_hs", obs_in_ready, 1'b0);
        tick();
        check("full_ready_after_last", obs_in_ready, 1'b1);
        run_drain(700);
        check("full_beats", out_cnt, 1152);

        // Reset mid-operation: granule 2 partly written while granule 1 drains
        new_test();
        rdy_mode = 0;
        for (int i = 0; i < 1152; i++) src.push_back(32'h5555_0000 + 32'(i));
        run_until_in(776, 900);
        rdy_mode = 1;
        run_until_out(100, 200);
        check("rst_mid_valid_before", out_valid, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        src.delete();
        exp_q.delete();
        src_idx = 0;
        gran_pos = 0;
        hold_pend = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("rst_hold_valid", out_valid, 1'b0);
        check("rst_hold_ready", in_ready, 1'b0);
        #1 reset = 1'b1;
        #1 check("rel_ready_before_edge", in_ready, 1'b0);
        new_test();
        for (int i = 0; i < 576; i++) src.push_back(32'hA000_0000 + 32'(i * 3));
        run_src(700);
        run_drain(700);
        check("post_rst_latency", first_valid_tick - last_in_tick, 3);
        check("post_rst_beat33", obs_log[33], 32'h5FFF_FFC7);
        check("post_rst_beat0",  obs_log[0],  32'hA000_0000);
        check("post_rst_beats",  out_cnt, 576);
        repeat (3) tick();
        check("post_rst_idle", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
